// File: rtl/bram_sp_arbiter_pkg.sv
// Shared types and constants for the two-requester single-port BRAM arbiter.
// State encodings are fixed 2-bit values; RD_LAT is accept-to-rvalid latency.
package bram_sp_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int RD_LAT         = 2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/bram_sp_arbiter_if.sv
// Per-requester command/response bundle: valid/ready command handshake plus read strobe.
// master = requester side, slave = arbiter side.
interface bram_sp_arbiter_if
  import bram_sp_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  valid;
  logic                  ready;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;

  modport master (output valid, output wr, output addr, output wdata,
                  input  ready, input  rvalid);

  modport slave  (input  valid, input  wr, input  addr, input  wdata,
                  output ready, output rvalid);

endinterface

// File: rtl/bram.sv
// Single-port synchronous BRAM: write and registered read on the same clock edge.
module bram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[addr] <= data_in;
    end
    data_out <= mem[addr];
  end

endmodule

// File: rtl/bram_sp_arbiter_rr_arb2.sv
// Two-way round-robin grant. On contention the requester that did not win last gets the grant.
// The last-winner pointer moves only when a grant is issued (every grant is an accept).
module rr_arb2
  import bram_sp_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t last_winner;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) begin
        gnt = (last_winner == REQ_A) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= REQ_A;
    end else if (gnt[1]) begin
      last_winner <= REQ_B;
    end else if (gnt[0]) begin
      last_winner <= REQ_A;
    end
  end

endmodule

// File: rtl/bram_sp_arbiter.sv
// Shares one single-port synchronous BRAM between requesters A and B with round-robin
// arbitration; zero-fills the memory after reset or on clr_start before serving traffic.
module bram_sp_arbiter
  import bram_sp_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_start,
  output logic                  init_done,
  bram_sp_arbiter_if.slave      a,
  bram_sp_arbiter_if.slave      b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bram_wr,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   clr_cnt, clr_cnt_nxt;
  logic                  drain_cnt, drain_cnt_nxt;
  logic                  arb_en;
  logic [1:0]            gnt;
  logic                  accept;
  logic                  acc_wr;
  logic                  acc_owner_b;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [RD_LAT-1:0]     pipe_valid;
  logic [RD_LAT-1:0]     pipe_owner_b;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({b.valid, a.valid}),
    .gnt (gnt)
  );

  assign a.ready     = gnt[0];
  assign b.ready     = gnt[1];
  assign accept      = gnt[0] | gnt[1];
  assign acc_owner_b = gnt[1];
  assign acc_wr      = gnt[1] ? b.wr    : a.wr;
  assign acc_addr    = gnt[1] ? b.addr  : a.addr;
  assign acc_wdata   = gnt[1] ? b.wdata : a.wdata;

  // DRAIN lasts two cycles so reads accepted just before it still get their rvalid.
  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    drain_cnt_nxt = drain_cnt;
    init_done     = 1'b0;
    arb_en        = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        init_done = 1'b1;
        arb_en    = ~rst;
        if (clr_start) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end else begin
          drain_cnt_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      drain_cnt  <= 1'b0;
      bram_wr    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (state == ST_CLEAR) begin
        bram_wr    <= 1'b1;
        bram_addr  <= clr_cnt[ADDR_WIDTH-1:0];
        bram_wdata <= '0;
      end else if (accept) begin
        bram_wr    <= acc_wr;
        bram_addr  <= acc_addr;
        bram_wdata <= acc_wdata;
      end else begin
        bram_wr <= 1'b0;
      end
    end
  end

  // Stage 0 loads at the accept edge; the last stage lines up with valid bram_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid   <= '0;
      pipe_owner_b <= '0;
    end else begin
      pipe_valid   <= {pipe_valid[RD_LAT-2:0], accept & ~acc_wr};
      pipe_owner_b <= {pipe_owner_b[RD_LAT-2:0], acc_owner_b};
    end
  end

  assign a.rvalid = pipe_valid[RD_LAT-1] & ~pipe_owner_b[RD_LAT-1];
  assign b.rvalid = pipe_valid[RD_LAT-1] &  pipe_owner_b[RD_LAT-1];
  assign rdata    = bram_rdata;

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Directed bench for bram_sp_arbiter driving a real bram model; inputs change 1 time unit
// after the rising edge and outputs are sampled 2 units after it.
module tb_bram_sp_arbiter;
  import bram_sp_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_start;
  logic       init_done;
  logic [7:0] rdata;
  logic       bram_wr;
  logic [3:0] bram_addr;
  logic [7:0] bram_wdata;
  logic [7:0] bram_rdata;
  int         errors = 0;
  int         checks = 0;

  bram_sp_arbiter_if a_if ();
  bram_sp_arbiter_if b_if ();

  bram_sp_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .clr_start  (clr_start),
    .init_done  (init_done),
    .a          (a_if),
    .b          (b_if),
    .rdata      (rdata),
    .bram_wr    (bram_wr),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  bram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_bram (
    .clk      (clk),
    .wr       (bram_wr),
    .addr     (bram_addr),
    .data_in  (bram_wdata),
    .data_out (bram_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic w, input logic [3:0] ad, input logic [7:0] d);
    a_if.valid = v; a_if.wr = w; a_if.addr = ad; a_if.wdata = d;
  endtask

  task automatic set_b(input logic v, input logic w, input logic [3:0] ad, input logic [7:0] d);
    b_if.valid = v; b_if.wr = w; b_if.addr = ad; b_if.wdata = d;
  endtask

  task automatic test_reset;
    int n;
    clr_start = 1'b0;
    set_a(1'b1, 1'b0, 4'd0, 8'h00);
    set_b(1'b1, 1'b0, 4'd0, 8'h00);
    rst = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready: got a=%b b=%b want 0 0", a_if.ready, b_if.ready);
    end
    checks++;
    if (init_done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_init_done: got %b want 0", init_done);
    end
    rst = 1'b0;
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    set_b(1'b0, 1'b0, 4'd0, 8'h00);
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++; $display("[TB] FAIL init_latency: got %0d cycles want 16", n);
    end
    // Stream reads of every address; each rvalid arrives two cycles after its accept.
    for (int i = 0; i < 18; i++) begin
      if (i < 16) set_a(1'b1, 1'b0, 4'(i), 8'h00);
      else        set_a(1'b0, 1'b0, 4'd0, 8'h00);
      #1;
      if (i < 16) begin
        checks++;
        if (a_if.ready !== 1'b1) begin
          errors++; $display("[TB] FAIL fill_rd_ready[%0d]: got %b want 1", i, a_if.ready);
        end
      end
      if (i >= 2) begin
        checks++;
        if (a_if.rvalid !== 1'b1 || b_if.rvalid !== 1'b0 || rdata !== 8'h00) begin
          errors++;
          $display("[TB] FAIL fill_rd_data[%0d]: got rv=%b/%b data=%h want 1/0 00",
                   i - 2, a_if.rvalid, b_if.rvalid, rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_read;
    set_a(1'b1, 1'b1, 4'd6, 8'h5A);
    #1;
    checks++;
    if (a_if.ready !== 1'b1) begin
      errors++; $display("[TB] FAIL wr_a_ready: got %b want 1", a_if.ready);
    end
    tick();
    set_a(1'b1, 1'b0, 4'd6, 8'h00);
    #1;
    checks++;
    if (a_if.ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rd_a_ready: got %b want 1", a_if.ready);
    end
    tick();
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    checks++;
    if (a_if.rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_a_early: got rvalid=%b want 0", a_if.rvalid);
    end
    tick();
    #1;
    checks++;
    if (a_if.rvalid !== 1'b1 || b_if.rvalid !== 1'b0 || rdata !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL wr_then_rd: got rv=%b/%b data=%h want 1/0 5a", a_if.rvalid, b_if.rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_b_write;
    set_b(1'b1, 1'b1, 4'd15, 8'hC3);
    #1;
    checks++;
    if (b_if.ready !== 1'b1 || a_if.ready !== 1'b0) begin
      errors++; $display("[TB] FAIL b_wr_ready: got a=%b b=%b want 0 1", a_if.ready, b_if.ready);
    end
    tick();
    set_b(1'b0, 1'b0, 4'd0, 8'h00);
    set_a(1'b1, 1'b0, 4'd15, 8'h00);
    tick();
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    set_b(1'b1, 1'b0, 4'd15, 8'h00);
    #1;
    checks++;
    if (b_if.ready !== 1'b1) begin
      errors++; $display("[TB] FAIL b_rd_ready: got %b want 1", b_if.ready);
    end
    tick();
    set_b(1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    checks++;
    if (a_if.rvalid !== 1'b1 || b_if.rvalid !== 1'b0 || rdata !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL a_rd_b_data: got rv=%b/%b data=%h want 1/0 c3", a_if.rvalid, b_if.rvalid, rdata);
    end
    tick();
    #1;
    checks++;
    if (a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b1 || rdata !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL b_rd_b_data: got rv=%b/%b data=%h want 0/1 c3", a_if.rvalid, b_if.rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_alternate;
    logic       exp_a;
    logic [7:0] exp_d;
    // B won last, so contention starts with A.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        set_a(1'b1, 1'b0, 4'd6, 8'h00);
        set_b(1'b1, 1'b0, 4'd15, 8'h00);
      end else begin
        set_a(1'b0, 1'b0, 4'd0, 8'h00);
        set_b(1'b0, 1'b0, 4'd0, 8'h00);
      end
      #1;
      if (i < 4) begin
        exp_a = (i % 2 == 0);
        checks++;
        if (a_if.ready !== exp_a || b_if.ready !== ~exp_a) begin
          errors++;
          $display("[TB] FAIL alt_grant[%0d]: got a=%b b=%b want %b %b", i, a_if.ready, b_if.ready, exp_a, ~exp_a);
        end
      end
      if (i >= 2) begin
        exp_a = ((i - 2) % 2 == 0);
        exp_d = exp_a ? 8'h5A : 8'hC3;
        checks++;
        if (a_if.rvalid !== exp_a || b_if.rvalid !== ~exp_a || rdata !== exp_d) begin
          errors++;
          $display("[TB] FAIL alt_rdata[%0d]: got rv=%b/%b data=%h want %b/%b %h",
                   i, a_if.rvalid, b_if.rvalid, rdata, exp_a, ~exp_a, exp_d);
        end
      end
      tick();
    end
  endtask

  task automatic test_clear;
    int low;
    for (int i = 0; i < 5; i++) begin
      set_a(1'b1, 1'b0, 4'd6, 8'h00);
      clr_start = (i == 2);
      #1;
      checks++;
      if (a_if.ready !== (i <= 2)) begin
        errors++; $display("[TB] FAIL clr_ready[%0d]: got %b want %b", i, a_if.ready, (i <= 2));
      end
      if (i >= 2) begin
        checks++;
        if (a_if.rvalid !== 1'b1 || rdata !== 8'h5A) begin
          errors++; $display("[TB] FAIL clr_inflight[%0d]: got rv=%b data=%h want 1 5a", i, a_if.rvalid, rdata);
        end
      end
      if (i >= 3) begin
        checks++;
        if (init_done !== 1'b0) begin
          errors++; $display("[TB] FAIL clr_drain_done[%0d]: got %b want 0", i, init_done);
        end
      end
      tick();
    end
    // A keeps requesting through DRAIN/CLEAR; a clr_start pulse mid-fill must be ignored.
    low = 2;
    while (init_done !== 1'b1 && low < 60) begin
      clr_start = (low == 8);
      low++;
      tick();
    end
    clr_start = 1'b0;
    checks++;
    if (low !== 18) begin
      errors++; $display("[TB] FAIL clr_low_cycles: got %0d want 18", low);
    end
    set_a(1'b1, 1'b0, 4'd15, 8'h00);
    #1;
    checks++;
    if (a_if.ready !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_post_ready: got %b want 1", a_if.ready);
    end
    tick();
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    #1;
    checks++;
    if (a_if.rvalid !== 1'b1 || rdata !== 8'h00) begin
      errors++; $display("[TB] FAIL clr_rd15: got rv=%b data=%h want 1 00", a_if.rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int n;
    set_a(1'b1, 1'b0, 4'd6, 8'h00);
    tick();
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (a_if.rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_drop_rvalid: got %b want 0", a_if.rvalid);
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bram_addr !== 4'd6 || bram_wr !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_clear_addr: got addr=%0d wr=%b want 6 1", bram_addr, bram_wr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if (bram_addr !== 4'd0 || bram_wr !== 1'b1) begin
          errors++; $display("[TB] FAIL restart_addr: got addr=%0d wr=%b want 0 1", bram_addr, bram_wr);
        end
      end
    end
    checks++;
    if (n !== 16) begin
      errors++; $display("[TB] FAIL rst_mid_latency: got %0d cycles want 16", n);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_b_write();
    test_alternate();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
